// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle control unit: FSM state codes,
// supported opcodes, ALUOp codes (also used by the ALU-control stage), the
// instruction classes produced by opcode_dec, the mux select codes, and a
// packed bundle of every control output so the FSM can default them in one go.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    // State codes are visible on the debug port, so they are pinned explicitly.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC_R = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_EXEC_I = 4'd9,
        ST_IWB    = 4'd10,
        ST_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_FUNCT = 3'b110;
    localparam logic [2:0] ALU_SLTU  = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_LW      = 3'd1,
        CLS_SW      = 3'd2,
        CLS_RTYPE   = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_BNE     = 3'd5,
        CLS_ITYPE   = 3'd6,
        CLS_JUMP    = 3'd7
    } instr_class_t;

    typedef struct packed {
        logic       PCWrite;
        logic       IRWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       IorD;
        logic       RegWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] PCSource;
        logic [2:0] ALUOp;
        logic       Branch;
        logic       BranchNe;
        logic       illegal_op;
    } ctrl_out_t;

endpackage

// File: rtl/ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_if
// Bundles the control unit's instruction/memory inputs and all datapath
// control outputs.
//   master : the control FSM (drives controls, receives opcode/Jr/mem_ready)
//   slave  : the datapath side (drives opcode/Jr/mem_ready, receives controls)
// Signals: opcode[5:0], Jr, mem_ready, PCWrite, IRWrite, MemRead, MemWrite,
// IorD, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB[1:0], PCSource[1:0],
// ALUOp[2:0], Branch, BranchNe, illegal_op, state (debug).
// ---------------------------------------------------------------------------
interface ctrl_fsm_if;
    import ctrl_pkg::*;

    logic [5:0] opcode;
    logic       Jr;
    logic       mem_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [2:0] ALUOp;
    logic       Branch;
    logic       BranchNe;
    logic       illegal_op;
    state_t     state;

    modport master (
        input  opcode, Jr, mem_ready,
        output PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Branch, BranchNe,
               illegal_op, state
    );

    modport slave (
        output opcode, Jr, mem_ready,
        input  PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Branch, BranchNe,
               illegal_op, state
    );

endinterface

// File: rtl/opcode_dec.sv
// ---------------------------------------------------------------------------
// opcode_dec
// Purely combinational opcode classifier.
//   i_opcode     : instruction[31:26]
//   o_class      : instruction class steering the FSM out of DECODE/MEMADR
//   o_immAluOp   : ALU operation for immediate-arithmetic instructions
// Anything not recognised is reported as CLS_ILLEGAL.
// ---------------------------------------------------------------------------
module opcode_dec
    import ctrl_pkg::*;
(
    input  logic [5:0]   i_opcode,
    output instr_class_t o_class,
    output logic [2:0]   o_immAluOp
);

    // Map each supported opcode to its class; the immediate ALUOp only
    // matters for the I-type class and defaults to add otherwise.
    always_comb begin
        o_class    = CLS_ILLEGAL;
        o_immAluOp = ALU_ADD;
        case (i_opcode)
            OP_LW:    o_class = CLS_LW;
            OP_SW:    o_class = CLS_SW;
            OP_RTYPE: o_class = CLS_RTYPE;
            OP_BEQ:   o_class = CLS_BEQ;
            OP_BNE:   o_class = CLS_BNE;
            OP_J:     o_class = CLS_JUMP;
            OP_ADDI: begin
                o_class    = CLS_ITYPE;
                o_immAluOp = ALU_ADD;
            end
            OP_ANDI: begin
                o_class    = CLS_ITYPE;
                o_immAluOp = ALU_AND;
            end
            OP_ORI: begin
                o_class    = CLS_ITYPE;
                o_immAluOp = ALU_OR;
            end
            OP_XORI: begin
                o_class    = CLS_ITYPE;
                o_immAluOp = ALU_XOR;
            end
            OP_SLTI: begin
                o_class    = CLS_ITYPE;
                o_immAluOp = ALU_SLT;
            end
            OP_SLTIU: begin
                o_class    = CLS_ITYPE;
                o_immAluOp = ALU_SLTU;
            end
            default: begin
                o_class    = CLS_ILLEGAL;
                o_immAluOp = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ctrl_fsm
// Multicycle MIPS-style control unit.
//   clk    : single clock, all state changes on the rising edge
//   reset  : synchronous active-high; while high all controls read 0 and the
//            debug state shows FETCH
//   bus    : ctrl_fsm_if master (opcode, Jr, mem_ready in; controls out)
// Parameter WAIT_MEM: 1 = honour mem_ready, 0 = memory always ready.
// ---------------------------------------------------------------------------
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter bit WAIT_MEM = 1'b1
)
(
    input  logic clk,
    input  logic reset,
    ctrl_fsm_if.master bus
);

    state_t       r_state;
    state_t       w_nextState;
    instr_class_t w_class;
    logic [2:0]   w_immAluOp;
    logic         w_memReady;
    ctrl_out_t    w_out;
    ctrl_out_t    w_gated;

    assign w_memReady = WAIT_MEM ? bus.mem_ready : 1'b1;

    opcode_dec u_opcodeDec (
        .i_opcode   (bus.opcode),
        .o_class    (w_class),
        .o_immAluOp (w_immAluOp)
    );

    // State register. Reset wins from any state, including memory waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control decode. Every control starts at 0 and each state
    // raises only what it needs. FETCH is Mealy: the IR and PC are written in
    // the cycle memory actually returns the instruction.
    always_comb begin
        w_out       = '0;
        w_nextState = ST_FETCH;
        case (r_state)
            ST_FETCH: begin
                w_out.MemRead = 1'b1;
                w_out.ALUSrcB = SRCB_FOUR;
                w_out.IRWrite = w_memReady;
                w_out.PCWrite = w_memReady;
                w_nextState   = w_memReady ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                w_out.ALUSrcB = SRCB_IMMSH2;
                case (w_class)
                    CLS_LW, CLS_SW:   w_nextState = ST_MEMADR;
                    CLS_RTYPE:        w_nextState = ST_EXEC_R;
                    CLS_BEQ, CLS_BNE: w_nextState = ST_BRANCH;
                    CLS_ITYPE:        w_nextState = ST_EXEC_I;
                    CLS_JUMP:         w_nextState = ST_JUMP;
                    default: begin
                        w_out.illegal_op = 1'b1;
                        w_nextState      = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                w_out.ALUSrcA = 1'b1;
                w_out.ALUSrcB = SRCB_IMM;
                if (w_class == CLS_LW) begin
                    w_nextState = ST_MEMRD;
                end else if (w_class == CLS_SW) begin
                    w_nextState = ST_MEMWR;
                end else begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_MEMRD: begin
                w_out.MemRead = 1'b1;
                w_out.IorD    = 1'b1;
                w_nextState   = w_memReady ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                w_out.RegWrite = 1'b1;
                w_out.MemtoReg = 1'b1;
                w_nextState    = ST_FETCH;
            end
            ST_MEMWR: begin
                w_out.MemWrite = 1'b1;
                w_out.IorD     = 1'b1;
                w_nextState    = w_memReady ? ST_FETCH : ST_MEMWR;
            end
            ST_EXEC_R: begin
                w_out.ALUSrcA = 1'b1;
                w_out.ALUSrcB = SRCB_B;
                w_out.ALUOp   = ALU_FUNCT;
                if (bus.Jr) begin
                    w_out.PCWrite  = 1'b1;
                    w_out.PCSource = PCSRC_REGA;
                    w_nextState    = ST_FETCH;
                end else begin
                    w_nextState = ST_ALUWB;
                end
            end
            ST_ALUWB: begin
                w_out.RegDst   = 1'b1;
                w_out.RegWrite = 1'b1;
                w_nextState    = ST_FETCH;
            end
            ST_BRANCH: begin
                w_out.ALUSrcA  = 1'b1;
                w_out.ALUSrcB  = SRCB_B;
                w_out.ALUOp    = ALU_SUB;
                w_out.PCSource = PCSRC_ALUOUT;
                w_out.Branch   = (w_class == CLS_BEQ);
                w_out.BranchNe = (w_class == CLS_BNE);
                w_nextState    = ST_FETCH;
            end
            ST_EXEC_I: begin
                w_out.ALUSrcA = 1'b1;
                w_out.ALUSrcB = SRCB_IMM;
                w_out.ALUOp   = w_immAluOp;
                w_nextState   = ST_IWB;
            end
            ST_IWB: begin
                w_out.RegWrite = 1'b1;
                w_nextState    = ST_FETCH;
            end
            ST_JUMP: begin
                w_out.PCWrite  = 1'b1;
                w_out.PCSource = PCSRC_JUMP;
                w_nextState    = ST_FETCH;
            end
            default: begin
                w_nextState = ST_FETCH;
            end
        endcase
    end

    // Reset blanks every control immediately, without waiting for the edge,
    // so an in-flight memory write is dropped in the same cycle.
    assign w_gated = reset ? '0 : w_out;

    assign bus.PCWrite    = w_gated.PCWrite;
    assign bus.IRWrite    = w_gated.IRWrite;
    assign bus.MemRead    = w_gated.MemRead;
    assign bus.MemWrite   = w_gated.MemWrite;
    assign bus.IorD       = w_gated.IorD;
    assign bus.RegWrite   = w_gated.RegWrite;
    assign bus.RegDst     = w_gated.RegDst;
    assign bus.MemtoReg   = w_gated.MemtoReg;
    assign bus.ALUSrcA    = w_gated.ALUSrcA;
    assign bus.ALUSrcB    = w_gated.ALUSrcB;
    assign bus.PCSource   = w_gated.PCSource;
    assign bus.ALUOp      = w_gated.ALUOp;
    assign bus.Branch     = w_gated.Branch;
    assign bus.BranchNe   = w_gated.BranchNe;
    assign bus.illegal_op = w_gated.illegal_op;
    assign bus.state      = reset ? ST_FETCH : r_state;

endmodule

// File: tb/tb_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_ctrl_fsm
// Directed bench for ctrl_fsm. Each instruction is expanded into the list of
// phases it must walk through; every driven cycle pushes the outputs that
// phase must show, and a compare process checks the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    typedef enum int {
        PH_RESET, PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB, PH_MEMWR,
        PH_EXEC_R, PH_ALUWB, PH_BRANCH, PH_EXEC_I, PH_IWB, PH_JUMP
    } phase_t;

    logic clk;
    logic reset;

    int compared   = 0;
    int mismatched = 0;
    int cycleNo    = 0;
    int illCount   = 0;
    int nonFetch   = 0;
    int lastLen    = 0;

    logic [22:0] expQ[$];
    phase_t      phQ[$];

    ctrl_fsm_if bus();

    ctrl_fsm #(.WAIT_MEM(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Required outputs for one cycle, derived from the phase the instruction
    // is in. Layout: state, PCWrite, IRWrite, MemRead, MemWrite, IorD,
    // RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Branch,
    // BranchNe, illegal_op.
    function automatic logic [22:0] expOf(input phase_t ph, input logic [5:0] opc,
                                          input logic jr, input logic mr);
        logic [3:0] st;
        logic pcw, irw, mrd, mwr, iord, rw, rd, m2r, asa, br, bn, ill;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
        {pcw, irw, mrd, mwr, iord, rw, rd, m2r, asa, br, bn, ill} = '0;
        asb = 2'b00;
        pcs = 2'b00;
        aop = 3'b000;
        st  = 4'd0;
        case (ph)
            PH_RESET:  st = 4'd0;
            PH_FETCH:  begin st = 4'd0; mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            PH_DECODE: begin
                st  = 4'd1;
                asb = 2'b11;
                ill = !(opc inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                    6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                                    6'b001011, 6'b000010});
            end
            PH_MEMADR: begin st = 4'd2; asa = 1'b1; asb = 2'b10; end
            PH_MEMRD:  begin st = 4'd3; mrd = 1'b1; iord = 1'b1; end
            PH_MEMWB:  begin st = 4'd4; rw = 1'b1; m2r = 1'b1; end
            PH_MEMWR:  begin st = 4'd5; mwr = 1'b1; iord = 1'b1; end
            PH_EXEC_R: begin
                st = 4'd6; asa = 1'b1; aop = 3'b110;
                if (jr) begin pcw = 1'b1; pcs = 2'b11; end
            end
            PH_ALUWB:  begin st = 4'd7; rd = 1'b1; rw = 1'b1; end
            PH_BRANCH: begin
                st = 4'd8; asa = 1'b1; aop = 3'b001; pcs = 2'b01;
                br = (opc == 6'b000100);
                bn = (opc == 6'b000101);
            end
            PH_EXEC_I: begin
                st = 4'd9; asa = 1'b1; asb = 2'b10;
                case (opc)
                    6'b001100: aop = 3'b010;
                    6'b001101: aop = 3'b011;
                    6'b001110: aop = 3'b100;
                    6'b001010: aop = 3'b101;
                    6'b001011: aop = 3'b111;
                    default:   aop = 3'b000;
                endcase
            end
            PH_IWB:    begin st = 4'd10; rw = 1'b1; end
            PH_JUMP:   begin st = 4'd11; pcw = 1'b1; pcs = 2'b10; end
            default:   st = 4'd0;
        endcase
        return {st, pcw, irw, mrd, mwr, iord, rw, rd, m2r, asa, asb, pcs, aop, br, bn, ill};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // One clock of stimulus plus the outputs that cycle must show.
    task automatic applyStimulus(input phase_t ph, input logic [5:0] opc, input logic jr,
                                 input logic mr, input logic rst);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.opcode    = opc;
        bus.Jr        = jr;
        bus.mem_ready = mr;
        expQ.push_back(expOf(ph, opc, jr, mr));
        phQ.push_back(ph);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its phase sequence, with memWaits
    // not-ready cycles in the memory-access phase.
    task automatic runInstr(input logic [5:0] opc, input logic jr, input int memWaits);
        applyStimulus(PH_FETCH, opc, jr, 1'b1, 1'b0);
        applyStimulus(PH_DECODE, opc, jr, rnd(), 1'b0);
        case (opc)
            6'b100011: begin
                applyStimulus(PH_MEMADR, opc, jr, rnd(), 1'b0);
                for (int i = 0; i < memWaits; i++) applyStimulus(PH_MEMRD, opc, jr, 1'b0, 1'b0);
                applyStimulus(PH_MEMRD, opc, jr, 1'b1, 1'b0);
                applyStimulus(PH_MEMWB, opc, jr, rnd(), 1'b0);
            end
            6'b101011: begin
                applyStimulus(PH_MEMADR, opc, jr, rnd(), 1'b0);
                for (int i = 0; i < memWaits; i++) applyStimulus(PH_MEMWR, opc, jr, 1'b0, 1'b0);
                applyStimulus(PH_MEMWR, opc, jr, 1'b1, 1'b0);
            end
            6'b000000: begin
                applyStimulus(PH_EXEC_R, opc, jr, rnd(), 1'b0);
                if (!jr) applyStimulus(PH_ALUWB, opc, jr, rnd(), 1'b0);
            end
            6'b000100, 6'b000101: applyStimulus(PH_BRANCH, opc, jr, rnd(), 1'b0);
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011: begin
                applyStimulus(PH_EXEC_I, opc, jr, rnd(), 1'b0);
                applyStimulus(PH_IWB, opc, jr, rnd(), 1'b0);
            end
            6'b000010: applyStimulus(PH_JUMP, opc, jr, rnd(), 1'b0);
            default: ;
        endcase
    endtask

    // A stalled FETCH cycle closes the previous instruction so its measured
    // FETCH-to-FETCH length can be checked against a hand-computed figure.
    task automatic idleCheck(input int expLen, input string name);
        applyStimulus(PH_FETCH, 6'b000000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput(name, lastLen, expLen);
    endtask

    // Compare every driven cycle on the falling edge, then track instruction
    // length (non-FETCH cycles plus the completing FETCH) and illegal pulses.
    initial begin : compareProc
        logic [22:0] got;
        logic [22:0] exp;
        phase_t      ph;
        forever begin
            @(negedge clk);
            cycleNo++;
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                ph  = phQ.pop_front();
                got = {4'(bus.state), bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite,
                       bus.IorD, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
                       bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.Branch, bus.BranchNe,
                       bus.illegal_op};
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL cycle%0d_%s: got %h, required %h",
                             cycleNo, ph.name(), got, exp);
                end
            end
            if (bus.illegal_op === 1'b1) illCount++;
            if (bus.state == ST_FETCH) begin
                if (nonFetch > 0) lastLen = nonFetch + 1;
                nonFetch = 0;
            end else begin
                nonFetch++;
            end
        end
    end

    initial begin : mainProc
        logic [22:0] pin;
        logic [5:0]  iOps[6];
        iOps = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011};

        reset         = 1'b1;
        bus.opcode    = 6'b000000;
        bus.Jr        = 1'b0;
        bus.mem_ready = 1'b1;

        // Hand-computed pins on the model itself.
        pin = expOf(PH_EXEC_I, 6'b001110, 1'b0, 1'b0);
        checkOutput("model_xori_aluop", int'(pin[5:3]), 4);
        pin = expOf(PH_BRANCH, 6'b000101, 1'b0, 1'b0);
        checkOutput("model_bne_flags", int'(pin[2:1]), 1);
        pin = expOf(PH_FETCH, 6'b000000, 1'b0, 1'b1);
        checkOutput("model_fetch_ready", int'(pin[18:16]), 7);

        // Two reset cycles, then FETCH with memory ready.
        applyStimulus(PH_RESET, 6'b000000, 1'b0, 1'b1, 1'b1);
        applyStimulus(PH_RESET, 6'b000000, 1'b0, 1'b1, 1'b1);

        runInstr(6'b100011, 1'b1, 2);
        idleCheck(7, "lw_2wait_len");
        runInstr(6'b101011, 1'b0, 1);
        idleCheck(5, "sw_1wait_len");
        runInstr(6'b000000, 1'b0, 0);
        idleCheck(4, "rtype_len");
        runInstr(6'b000000, 1'b1, 0);
        idleCheck(3, "jr_len");
        runInstr(6'b000101, 1'b0, 0);
        runInstr(6'b000100, 1'b0, 0);
        runInstr(6'b000100, 1'b1, 0);
        runInstr(6'b000101, 1'b1, 0);
        idleCheck(3, "bne_len");

        illCount = 0;
        runInstr(6'b111111, 1'b0, 0);
        idleCheck(2, "illegal_len");
        checkOutput("illegal_pulse_cycles", illCount, 1);

        foreach (iOps[i]) runInstr(iOps[i], 1'b0, 0);
        idleCheck(4, "itype_len");
        runInstr(6'b000010, 1'b0, 0);
        idleCheck(3, "jump_len");
        runInstr(6'b000001, 1'b0, 0);
        runInstr(6'b100011, 1'b0, 0);
        idleCheck(5, "lw_len");

        // Reset while a store is stalled: controls drop at once, FETCH next.
        applyStimulus(PH_FETCH, 6'b101011, 1'b0, 1'b1, 1'b0);
        applyStimulus(PH_DECODE, 6'b101011, 1'b0, 1'b0, 1'b0);
        applyStimulus(PH_MEMADR, 6'b101011, 1'b0, 1'b0, 1'b0);
        applyStimulus(PH_MEMWR, 6'b101011, 1'b0, 1'b0, 1'b0);
        applyStimulus(PH_RESET, 6'b101011, 1'b0, 1'b0, 1'b1);
        runInstr(6'b001000, 1'b0, 0);

        // Same while a load is stalled.
        applyStimulus(PH_FETCH, 6'b100011, 1'b0, 1'b1, 1'b0);
        applyStimulus(PH_DECODE, 6'b100011, 1'b0, 1'b0, 1'b0);
        applyStimulus(PH_MEMADR, 6'b100011, 1'b0, 1'b0, 1'b0);
        applyStimulus(PH_MEMRD, 6'b100011, 1'b0, 1'b0, 1'b0);
        applyStimulus(PH_RESET, 6'b100011, 1'b0, 1'b0, 1'b1);
        runInstr(6'b000000, 1'b0, 0);

        @(negedge clk);
        #1;
        checkOutput("queue_drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter: WAIT_MEM, default 1, meaning 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register; stable from DECODE until the next FETCH.
REQ-005 Jr  input  1  from the ALU-control stage; meaningful only while ALUOp=110.
REQ-006 mem_ready  input  1  memory access completes in the cycle it is high.
REQ-007 PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA  output  1 each  standard multicycle datapath controls.
REQ-008 ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-009 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A (jr).
REQ-010 ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 use funct, 111 sltu.
REQ-011 Branch, BranchNe  output  1 each  conditional PC write on zero / not-zero.
REQ-012 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 state  output  4  current state code, for debug.

Function
REQ-014 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, BRANCH, EXEC_I, IWB, JUMP. Any unlisted state code returns to FETCH on the next edge.
REQ-015 Every output not listed for a state is 0.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite and PCWrite equal mem_ready (Mealy). Stay in FETCH until mem_ready, then go to DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXEC_R
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 001000, 001100, 001101, 001110, 001010, 001011 -> EXEC_I
  - 000010 -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for that cycle.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Go to MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then go to MEMWB.
REQ-020 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1, held while waiting. Go to FETCH when mem_ready=1.
REQ-022 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=110.
  - Jr=1: PCWrite=1 and PCSource=11 in the same cycle, next state FETCH.
  - Jr=0: next state ALUWB.
REQ-023 ALUWB: RegDst=1, RegWrite=1, MemtoReg=0. Go to FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. Branch=1 for beq, BranchNe=1 for bne, never both. Go to FETCH.
REQ-025 EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp by opcode: addi 000, andi 010, ori 011, xori 100, slti 101, sltiu 111. Go to IWB.
REQ-026 IWB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
REQ-027 JUMP: PCWrite=1, PCSource=10. Go to FETCH.
REQ-028 Latency without waits: lw 5 cycles; sw, R-type and I-type 4; beq, bne, j and jr 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
REQ-029 Never assert MemRead and MemWrite together. Never assert IRWrite outside FETCH.

Reset
REQ-030 reset=1 at a clock edge: next state is FETCH regardless of current state, including mid-wait in MEMRD or MEMWR.
REQ-031 While reset=1, force all outputs to 0 combinationally; state output shows the FETCH code.
REQ-032 The first cycle after reset deasserts is FETCH with its normal outputs.

Structure
REQ-033 Shared package ctrl_pkg holds:
  - state encodings (4-bit)
  - opcode constants
  - ALUOp constants, shared with the ALU-control stage.
REQ-034 One combinational sub-module, opcode_dec, maps opcode to an instruction class and the immediate ALUOp. The FSM itself stays in ctrl_fsm.

Verification
REQ-035 reset=1 for 2 cycles, then release with mem_ready=1 -> all outputs 0 during reset; FETCH next cycle with MemRead=1, IRWrite=1, PCWrite=1.
REQ-036 lw (opcode 100011) with mem_ready=0 for 2 cycles in MEMRD -> 7 cycles FETCH-to-FETCH; RegWrite=1 and MemtoReg=1 only in MEMWB.
REQ-037 R-type with Jr=0 -> ALUOp=110 in EXEC_R, ALUWB next with RegDst=1. R-type with Jr=1 -> PCWrite=1, PCSource=11 in EXEC_R, FETCH next.
REQ-038 bne (000101), then beq (000100) -> BRANCH with BranchNe=1, Branch=0, ALUOp=001; then the reverse.
REQ-039 Opcode 111111 -> illegal_op high for exactly 1 cycle in DECODE, then FETCH. xori (001110) -> ALUOp=100 in EXEC_I.
REQ-040 reset asserted during MEMWR with mem_ready=0 -> MemWrite=0 immediately; FETCH after the edge; no IWB/MEMWB write.
